// File: rtl/verinject_pkg.sv
// Shared bus codes and command layout for the verinject injection infrastructure.
// Injectors and the sequencer both import these constants.
package verinject_pkg;

    localparam logic [31:0] VERINJECT_IDLE         = 32'hFFFF_FFFF;
    localparam logic [31:0] VERINJECT_RESET_BUFFER = 32'hFFFF_FFFE;
    localparam int unsigned VERINJECT_CYCLE_W      = 32;

    typedef struct packed {
        logic [VERINJECT_CYCLE_W-1:0] cycle;
        logic [31:0]                  target;
    } verinject_cmd_t;

endpackage

// File: rtl/verinject_sched_fifo.sv
// Synchronous FIFO holding scheduled injection commands; the head entry is
// read straight from the storage register, so it is available without a pop.
module verinject_sched_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/verinject_injection_sequencer.sv
// Cycle counter plus scheduled-command FIFO that drives the injector state bus:
// one target per matching cycle, RESET_BUFFER on request, IDLE otherwise.
module verinject_injection_sequencer
    import verinject_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CYCLE_W    = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CYCLE_W-1:0] cmd_cycle,
    input  logic [31:0]        cmd_target,
    input  logic               clear_req,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               busy,
    output logic               injected,
    output logic               missed,
    output logic [31:0]        verinject__injector_state
);

    // Same layout as verinject_cmd_t, but with the cycle field sized by CYCLE_W.
    typedef struct packed {
        logic [CYCLE_W-1:0] cycle;
        logic [31:0]        target;
    } sched_cmd_t;

    logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
    logic [31:0]        bus_q, bus_d;
    logic               injected_q, injected_d;
    logic               missed_q, missed_d;
    sched_cmd_t         push_cmd, head;
    logic               fifo_full, fifo_empty, pop;

    assign push_cmd = '{cycle: cmd_cycle, target: cmd_target};

    verinject_sched_fifo #(
        .WIDTH ($bits(sched_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        cycle_count_d = enable ? cycle_count_q + CYCLE_W'(1) : cycle_count_q;
        bus_d         = VERINJECT_IDLE;
        injected_d    = 1'b0;
        missed_d      = 1'b0;
        pop           = 1'b0;
        if (clear_req) begin
            bus_d = VERINJECT_RESET_BUFFER;
        end else if (enable && !fifo_empty) begin
            if (head.cycle == cycle_count_q) begin
                bus_d      = head.target;
                injected_d = 1'b1;
                pop        = 1'b1;
            end else if (head.cycle < cycle_count_q) begin
                missed_d = 1'b1;
                pop      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count_q <= '0;
            bus_q         <= VERINJECT_IDLE;
            injected_q    <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            cycle_count_q <= cycle_count_d;
            bus_q         <= bus_d;
            injected_q    <= injected_d;
            missed_q      <= missed_d;
        end
    end

    assign cmd_ready                 = !fifo_full;
    assign busy                      = !fifo_empty;
    assign cycle_count               = cycle_count_q;
    assign injected                  = injected_q;
    assign missed                    = missed_q;
    assign verinject__injector_state = bus_q;

endmodule
